// File: rtl/mcy_mutation_sequencer_if.sv
// Per-mutation result channel between the mutation sequencer and its consumer.
interface mcy_mutation_sequencer_if #(
  parameter int MUTSEL_W = 8
);
  // valid/ready: the master holds valid and every payload field stable until a cycle with
  // valid && ready (the handshake); valid drops the cycle after. ready may be driven freely.
  logic                result_valid_o;
  logic                result_ready_i;
  logic [MUTSEL_W-1:0] result_idx_o;
  logic                result_killed_o;
  logic                result_timeout_o;

  modport master (
    output result_valid_o, result_idx_o, result_killed_o, result_timeout_o,
    input  result_ready_i
  );

  modport slave (
    input  result_valid_o, result_idx_o, result_killed_o, result_timeout_o,
    output result_ready_i
  );
endinterface

// File: rtl/mcy_mutation_sequencer.sv
// Hardware loop for an MCY campaign: reset cores, run each mutation, classify it, report.
// Optional golden pre-run is compiled in with `define MCY_SEQ_GOLDEN_CHECK_EN.
module mcy_mutation_sequencer #(
  parameter int MUTSEL_W       = 8,
  parameter int NUM_MUTATIONS  = 16,
  parameter int RESET_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int TMO_W          = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  mismatch_i,
  input  logic                  test_done_i,
  output logic [MUTSEL_W-1:0]   mutsel_o,
  output logic                  core_rst_no,
  output logic                  fetch_enable_o,
  output logic                  busy_o,
  mcy_mutation_sequencer_if.master res,
  output logic [MUTSEL_W:0]     killed_count_o,
  output logic                  done_o,
  output logic                  golden_fail_o,
  output logic [2:0]            dbg_state_o
);

  if (NUM_MUTATIONS < 1 || NUM_MUTATIONS > (2 ** MUTSEL_W) - 1) begin : g_bad_num
    $error("NUM_MUTATIONS out of range for MUTSEL_W");
  end
  if (RESET_CYCLES < 1) begin : g_bad_rst
    $error("RESET_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 2 || longint'(TIMEOUT_CYCLES) >= (longint'(1) << TMO_W)) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES out of range for TMO_W");
  end

  localparam int RST_W = $clog2(RESET_CYCLES + 1);
  localparam logic [MUTSEL_W-1:0] LAST_IDX = MUTSEL_W'(NUM_MUTATIONS);
  localparam logic [RST_W-1:0]    RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_RUN, S_REPORT, S_DONE
`ifdef MCY_SEQ_GOLDEN_CHECK_EN
    , S_GOLDEN
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [TMO_W-1:0]    run_cnt_q, run_cnt_d;
  logic [MUTSEL_W-1:0] mutsel_q, mutsel_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic                fetch_en_q, fetch_en_d;
  logic                res_valid_q, res_valid_d;
  logic [MUTSEL_W-1:0] res_idx_q, res_idx_d;
  logic                res_killed_q, res_killed_d;
  logic                res_tmo_q, res_tmo_d;
  logic [MUTSEL_W:0]   killed_cnt_q, killed_cnt_d;
  logic                done_q, done_d;
  logic                tmo_hit;
`ifdef MCY_SEQ_GOLDEN_CHECK_EN
  logic                golden_q, golden_d;
  logic                gfail_q, gfail_d;
`endif

  assign tmo_hit = (run_cnt_q == TMO_LAST);

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    run_cnt_d    = run_cnt_q;
    mutsel_d     = mutsel_q;
    core_rst_n_d = core_rst_n_q;
    fetch_en_d   = fetch_en_q;
    res_valid_d  = res_valid_q;
    res_idx_d    = res_idx_q;
    res_killed_d = res_killed_q;
    res_tmo_d    = res_tmo_q;
    killed_cnt_d = killed_cnt_q;
    done_d       = done_q;
`ifdef MCY_SEQ_GOLDEN_CHECK_EN
    golden_d     = golden_q;
    gfail_d      = gfail_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d      = S_RESET;
          rst_cnt_d    = '0;
          killed_cnt_d = '0;
          done_d       = 1'b0;
`ifdef MCY_SEQ_GOLDEN_CHECK_EN
          mutsel_d     = '0;
          golden_d     = 1'b1;
          gfail_d      = 1'b0;
`else
          mutsel_d     = MUTSEL_W'(1);
`endif
        end
      end
      S_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
`ifdef MCY_SEQ_GOLDEN_CHECK_EN
          state_d    = golden_q ? S_GOLDEN : S_RUN;
`else
          state_d    = S_RUN;
`endif
          run_cnt_d    = '0;
          core_rst_n_d = 1'b1;
          fetch_en_d   = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      S_RUN: begin
        // Mismatch outranks test_done, which outranks the timeout.
        if (mismatch_i || test_done_i || tmo_hit) begin
          state_d      = S_REPORT;
          core_rst_n_d = 1'b0;
          fetch_en_d   = 1'b0;
          res_valid_d  = 1'b1;
          res_idx_d    = mutsel_q;
          res_killed_d = mismatch_i || !test_done_i;
          res_tmo_d    = !mismatch_i && !test_done_i;
        end else begin
          run_cnt_d = run_cnt_q + TMO_W'(1);
        end
      end
      S_REPORT: begin
        if (res.result_ready_i) begin
          res_valid_d  = 1'b0;
          killed_cnt_d = killed_cnt_q + (MUTSEL_W+1)'(res_killed_q);
          if (mutsel_q == LAST_IDX) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            mutsel_d = '0;
          end else begin
            state_d   = S_RESET;
            rst_cnt_d = '0;
            mutsel_d  = mutsel_q + MUTSEL_W'(1);
          end
        end
      end
`ifdef MCY_SEQ_GOLDEN_CHECK_EN
      S_GOLDEN: begin
        if (mismatch_i || (tmo_hit && !test_done_i)) begin
          state_d      = S_DONE;
          gfail_d      = 1'b1;
          done_d       = 1'b1;
          core_rst_n_d = 1'b0;
          fetch_en_d   = 1'b0;
        end else if (test_done_i) begin
          state_d      = S_RESET;
          rst_cnt_d    = '0;
          mutsel_d     = MUTSEL_W'(1);
          golden_d     = 1'b0;
          core_rst_n_d = 1'b0;
          fetch_en_d   = 1'b0;
        end else begin
          run_cnt_d = run_cnt_q + TMO_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      run_cnt_q    <= '0;
      mutsel_q     <= '0;
      core_rst_n_q <= 1'b0;
      fetch_en_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      res_idx_q    <= '0;
      res_killed_q <= 1'b0;
      res_tmo_q    <= 1'b0;
      killed_cnt_q <= '0;
      done_q       <= 1'b0;
`ifdef MCY_SEQ_GOLDEN_CHECK_EN
      golden_q     <= 1'b0;
      gfail_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      run_cnt_q    <= run_cnt_d;
      mutsel_q     <= mutsel_d;
      core_rst_n_q <= core_rst_n_d;
      fetch_en_q   <= fetch_en_d;
      res_valid_q  <= res_valid_d;
      res_idx_q    <= res_idx_d;
      res_killed_q <= res_killed_d;
      res_tmo_q    <= res_tmo_d;
      killed_cnt_q <= killed_cnt_d;
      done_q       <= done_d;
`ifdef MCY_SEQ_GOLDEN_CHECK_EN
      golden_q     <= golden_d;
      gfail_q      <= gfail_d;
`endif
    end
  end

  assign mutsel_o             = mutsel_q;
  assign core_rst_no          = core_rst_n_q;
  assign fetch_enable_o       = fetch_en_q;
  assign busy_o               = (state_q != S_IDLE) && (state_q != S_DONE);
  assign res.result_valid_o   = res_valid_q;
  assign res.result_idx_o     = res_idx_q;
  assign res.result_killed_o  = res_killed_q;
  assign res.result_timeout_o = res_tmo_q;
  assign killed_count_o       = killed_cnt_q;
  assign done_o               = done_q;
  assign dbg_state_o          = state_q;
`ifdef MCY_SEQ_GOLDEN_CHECK_EN
  assign golden_fail_o        = gfail_q;
`else
  assign golden_fail_o        = 1'b0;
`endif

endmodule

// File: tb/tb_mcy_mutation_sequencer.sv
// Directed, table-driven bench for mcy_mutation_sequencer (3 mutations, 8 reset cycles, timeout 50).
module tb_mcy_mutation_sequencer;
  localparam int MW  = 8;
  localparam int NUM = 3;
  localparam int RC  = 8;
  localparam int TMO = 50;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          mismatch_i = 1'b0;
  logic          test_done_i = 1'b0;
  logic [MW-1:0] mutsel_o;
  logic          core_rst_no;
  logic          fetch_enable_o;
  logic          busy_o;
  logic [MW:0]   killed_count_o;
  logic          done_o;
  logic          golden_fail_o;
  logic [2:0]    dbg_state_o;

  mcy_mutation_sequencer_if #(.MUTSEL_W(MW)) res_if ();

  mcy_mutation_sequencer #(
    .MUTSEL_W(MW), .NUM_MUTATIONS(NUM), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TMO), .TMO_W(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .mismatch_i(mismatch_i),
    .test_done_i(test_done_i), .mutsel_o(mutsel_o), .core_rst_no(core_rst_no),
    .fetch_enable_o(fetch_enable_o), .busy_o(busy_o), .res(res_if.master),
    .killed_count_o(killed_count_o), .done_o(done_o), .golden_fail_o(golden_fail_o),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int mis;       // RUN cycle to raise mismatch_i, -1 never
    int dn;        // RUN cycle to raise test_done_i, -1 never
    int rdy_wait;  // cycles result_ready_i is held low in REPORT
    bit exp_k;
    bit exp_t;
    int exp_len;   // RUN cycles until REPORT
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mutsel"}, 32'(mutsel_o), 0);
    check({tag, "_core_rst_n"}, 32'(core_rst_no), 0);
    check({tag, "_fetch"}, 32'(fetch_enable_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_valid"}, 32'(res_if.result_valid_o), 0);
    check({tag, "_idx"}, 32'(res_if.result_idx_o), 0);
    check({tag, "_killed"}, 32'(res_if.result_killed_o), 0);
    check({tag, "_timeout"}, 32'(res_if.result_timeout_o), 0);
    check({tag, "_kcount"}, 32'(killed_count_o), 0);
    check({tag, "_done"}, 32'(done_o), 0);
    check({tag, "_gfail"}, 32'(golden_fail_o), 0);
    check({tag, "_state"}, 32'(dbg_state_o), 0);
  endtask

  // Waits out the core reset window of one run, returning its length in cycles.
  task automatic wait_reset(input int exp_idx, output int n);
    n = 0;
    while (core_rst_no !== 1'b1 && n < 100) begin
      if (n == 0) check("mutsel_first_reset", 32'(mutsel_o), exp_idx);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic start_campaign();
    int n;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("start_done_clr", 32'(done_o), 0);
    check("start_kcount_clr", 32'(killed_count_o), 0);
    check("start_busy", 32'(busy_o), 1);
`ifdef MCY_SEQ_GOLDEN_CHECK_EN
    wait_reset(0, n);
    check("golden_reset_len", n, RC);
    test_done_i = 1'b1;
    @(negedge clk);
    test_done_i = 1'b0;
    check("golden_no_result", 32'(res_if.result_valid_o), 0);
`endif
  endtask

  task automatic run_mutation(input int idx, input vec_t v);
    int n;
    wait_reset(idx, n);
    check("reset_len", n, RC);
    check("fetch_en_run", 32'(fetch_enable_o), 1);
    n = 0;
    while (res_if.result_valid_o !== 1'b1 && n < 200) begin
      mismatch_i  = (n == v.mis);
      test_done_i = (n == v.dn);
      @(negedge clk);
      n++;
    end
    mismatch_i  = 1'b0;
    test_done_i = 1'b0;
    check("run_len", n, v.exp_len);
    check("res_idx", 32'(res_if.result_idx_o), idx);
    check("res_killed", 32'(res_if.result_killed_o), 32'(v.exp_k));
    check("res_timeout", 32'(res_if.result_timeout_o), 32'(v.exp_t));
    check("report_core_rst", 32'(core_rst_no), 0);
    if (v.rdy_wait > 0) begin
      res_if.result_ready_i = 1'b0;
      for (int i = 0; i < v.rdy_wait; i++) begin
        start_i = (i % 3 == 1);
        @(negedge clk);
        check("hold_valid", 32'(res_if.result_valid_o), 1);
        check("hold_idx", 32'(res_if.result_idx_o), idx);
        check("hold_killed", 32'(res_if.result_killed_o), 32'(v.exp_k));
        check("hold_core_rst", 32'(core_rst_no), 0);
        check("hold_fetch", 32'(fetch_enable_o), 0);
      end
      start_i = 1'b0;
      res_if.result_ready_i = 1'b1;
    end
    @(negedge clk);
    check("valid_drop", 32'(res_if.result_valid_o), 0);
  endtask

  initial begin
    int exp_kc;
    int n;
    res_if.result_ready_i = 1'b1;
    vecs[0] = '{-1, 20, 0, 1'b0, 1'b0, 21};
    vecs[1] = '{-1, 20, 0, 1'b0, 1'b0, 21};
    vecs[2] = '{-1, 20, 0, 1'b0, 1'b0, 21};
    vecs[3] = '{-1, 20, 0, 1'b0, 1'b0, 21};
    vecs[4] = '{ 5, 20, 0, 1'b1, 1'b0,  6};
    vecs[5] = '{-1, 20, 0, 1'b0, 1'b0, 21};
    vecs[6] = '{-1, -1, 0, 1'b1, 1'b1, 50};
    vecs[7] = '{ 7,  7, 0, 1'b1, 1'b0,  8};
    vecs[8] = '{49, -1, 0, 1'b1, 1'b0, 50};

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy_o), 0);
    check("idle_core_rst", 32'(core_rst_no), 0);

    for (int c = 0; c < 3; c++) begin
      start_campaign();
      exp_kc = 0;
      for (int j = 0; j < NUM; j++) begin
        run_mutation(j + 1, vecs[c * 3 + j]);
        exp_kc += int'(vecs[c * 3 + j].exp_k);
      end
      check("camp_done", 32'(done_o), 1);
      check("camp_kcount", 32'(killed_count_o), exp_kc);
      check("camp_mutsel", 32'(mutsel_o), 0);
      check("camp_busy", 32'(busy_o), 0);
      check("camp_core_rst", 32'(core_rst_no), 0);
      check("camp_gfail", 32'(golden_fail_o), 0);
    end

    // Back-pressure with stray start pulses, then asynchronous reset mid-RUN.
    start_campaign();
    run_mutation(1, '{-1, 3, 10, 1'b0, 1'b0, 4});
    wait_reset(2, n);
    check("seq_reset_len", n, RC);
    repeat (5) @(negedge clk);
    check("seq_fetch_before_rst", 32'(fetch_enable_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_state", 32'(dbg_state_o), 0);
    check("post_rst_valid", 32'(res_if.result_valid_o), 0);

`ifdef MCY_SEQ_GOLDEN_CHECK_EN
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_reset(0, n);
    mismatch_i = 1'b1;
    @(negedge clk);
    mismatch_i = 1'b0;
    n = 0;
    repeat (3) begin
      if (res_if.result_valid_o === 1'b1) n++;
      @(negedge clk);
    end
    check("gfail_flag", 32'(golden_fail_o), 1);
    check("gfail_done", 32'(done_o), 1);
    check("gfail_no_result", n, 0);
    check("gfail_kcount", 32'(killed_count_o), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
